// File: rtl/chan_param_bank.sv
// Per-channel parameter bank. Host writes go to shadow registers; a masked commit copies
// shadow to active and pulses update_en. Also latches and snapshots per-channel ADC samples
// and serves registered readback of any shadow or active register.
module chan_param_bank #(
  parameter int unsigned N_CHAN = 8,
  parameter int unsigned W_DATA = 16,
  parameter int unsigned W_ADC  = 18,
  parameter int unsigned W_CH   = 4
) (
  input  logic                       clk50_in,
  input  logic                       reset_in,
  input  logic                       wr_en_in,
  input  logic [W_CH-1:0]            wr_chan_in,
  input  logic [2:0]                 wr_addr_in,
  input  logic [W_DATA-1:0]          wr_data_in,
  input  logic                       commit_in,
  input  logic [N_CHAN-1:0]          commit_mask_in,
  input  logic                       rd_en_in,
  input  logic [W_CH-1:0]            rd_chan_in,
  input  logic [3:0]                 rd_addr_in,
  output logic [W_DATA-1:0]          rd_data_out,
  output logic                       rd_valid_out,
  input  logic                       snap_in,
  input  logic [N_CHAN-1:0]          adc_valid_in,
  input  logic [N_CHAN*W_ADC-1:0]    adc_data_in,
  output logic [N_CHAN*W_ADC-1:0]    adc_snap_out,
  output logic [N_CHAN-1:0]          adc_fresh_out,
  output logic [N_CHAN*W_DATA-1:0]   setpoint_out,
  output logic [N_CHAN*W_DATA-1:0]   p_coef_out,
  output logic [N_CHAN*W_DATA-1:0]   i_coef_out,
  output logic [N_CHAN*W_DATA-1:0]   d_coef_out,
  output logic [N_CHAN*W_DATA-1:0]   osf_cycle_delay_out,
  output logic [N_CHAN*W_DATA-1:0]   osf_log_ovr_out,
  output logic [N_CHAN*W_DATA-1:0]   src_sel_out,
  output logic [N_CHAN-1:0]          lock_en_out,
  output logic [N_CHAN-1:0]          update_en_out,
  output logic [N_CHAN-1:0]          dirty_out,
  output logic                       wr_err_out
);

  localparam int unsigned NReg = 8;
  localparam logic [W_CH:0] NChanLim = (W_CH+1)'(N_CHAN);

  logic [W_DATA-1:0] shadow_q [N_CHAN][NReg];
  logic [W_DATA-1:0] shadow_d [N_CHAN][NReg];
  logic [W_DATA-1:0] active_q [N_CHAN][NReg];
  logic [W_DATA-1:0] active_d [N_CHAN][NReg];
  logic [W_ADC-1:0]  latch_q  [N_CHAN];
  logic [W_ADC-1:0]  latch_d  [N_CHAN];
  logic [W_ADC-1:0]  snap_q   [N_CHAN];
  logic [W_ADC-1:0]  snap_d   [N_CHAN];
  logic [N_CHAN-1:0] dirty_q, dirty_d;
  logic [N_CHAN-1:0] upd_q, upd_d;
  logic [N_CHAN-1:0] fresh_q, fresh_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [W_DATA-1:0] rd_data_q, rd_data_d;
  logic              wr_ok;

  assign wr_ok = ({1'b0, wr_chan_in} < NChanLim);

  // Commit copies the pre-write shadow; a same-cycle write then lands and re-dirties.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    upd_d    = '0;
    wr_err_d = wr_en_in & ~wr_ok;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      if (commit_in && commit_mask_in[c]) begin
        for (int unsigned r = 0; r < NReg; r++) begin
          active_d[c][r] = shadow_q[c][r];
        end
        upd_d[c]   = 1'b1;
        dirty_d[c] = 1'b0;
      end
      if (wr_en_in && wr_ok && (wr_chan_in == W_CH'(c))) begin
        shadow_d[c][wr_addr_in] = wr_data_in;
        dirty_d[c]              = 1'b1;
      end
    end
  end

  // Readback mux from current (pre-write) state; out-of-range channels match nothing -> 0.
  always_comb begin
    rd_valid_d = rd_en_in;
    rd_data_d  = rd_data_q;
    if (rd_en_in) begin
      rd_data_d = '0;
      for (int unsigned c = 0; c < N_CHAN; c++) begin
        for (int unsigned r = 0; r < NReg; r++) begin
          if ((rd_chan_in == W_CH'(c)) && (rd_addr_in[2:0] == 3'(r))) begin
            rd_data_d = rd_addr_in[3] ? active_q[c][r] : shadow_q[c][r];
          end
        end
      end
    end
  end

  // ADC latch and snapshot; snapshot sees the old latch, a concurrent sample re-sets fresh.
  always_comb begin
    latch_d = latch_q;
    snap_d  = snap_q;
    fresh_d = fresh_q;
    if (snap_in) begin
      snap_d  = latch_q;
      fresh_d = '0;
    end
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      if (adc_valid_in[c]) begin
        latch_d[c] = adc_data_in[c*W_ADC +: W_ADC];
        fresh_d[c] = 1'b1;
      end
    end
  end

  // State registers with synchronous reset overriding all concurrent activity.
  always_ff @(posedge clk50_in) begin
    if (reset_in) begin
      for (int unsigned c = 0; c < N_CHAN; c++) begin
        for (int unsigned r = 0; r < NReg; r++) begin
          shadow_q[c][r] <= '0;
          active_q[c][r] <= '0;
        end
        latch_q[c] <= '0;
        snap_q[c]  <= '0;
      end
      dirty_q    <= '0;
      upd_q      <= '0;
      fresh_q    <= '0;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      latch_q    <= latch_d;
      snap_q     <= snap_d;
      dirty_q    <= dirty_d;
      upd_q      <= upd_d;
      fresh_q    <= fresh_d;
      wr_err_q   <= wr_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Flatten active registers and snapshot onto the output buses.
  always_comb begin
    setpoint_out        = '0;
    p_coef_out          = '0;
    i_coef_out          = '0;
    d_coef_out          = '0;
    osf_cycle_delay_out = '0;
    osf_log_ovr_out     = '0;
    src_sel_out         = '0;
    lock_en_out         = '0;
    adc_snap_out        = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      setpoint_out[c*W_DATA +: W_DATA]        = active_q[c][0];
      p_coef_out[c*W_DATA +: W_DATA]          = active_q[c][1];
      i_coef_out[c*W_DATA +: W_DATA]          = active_q[c][2];
      d_coef_out[c*W_DATA +: W_DATA]          = active_q[c][3];
      osf_cycle_delay_out[c*W_DATA +: W_DATA] = active_q[c][4];
      osf_log_ovr_out[c*W_DATA +: W_DATA]     = active_q[c][5];
      lock_en_out[c]                          = active_q[c][6][0];
      src_sel_out[c*W_DATA +: W_DATA]         = active_q[c][7];
      adc_snap_out[c*W_ADC +: W_ADC]          = snap_q[c];
    end
  end

  assign rd_data_out   = rd_data_q;
  assign rd_valid_out  = rd_valid_q;
  assign adc_fresh_out = fresh_q;
  assign update_en_out = upd_q;
  assign dirty_out     = dirty_q;
  assign wr_err_out    = wr_err_q;

endmodule

// File: tb/tb_chan_param_bank.sv
// Bench for chan_param_bank: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a behavioural model of the register bank.
module tb_chan_param_bank;

  localparam int N = 8;
  localparam int WD = 16;
  localparam int WA = 18;
  localparam int WC = 4;

  logic clk50_in = 1'b0;
  logic reset_in;
  logic wr_en_in;
  logic [WC-1:0] wr_chan_in;
  logic [2:0] wr_addr_in;
  logic [WD-1:0] wr_data_in;
  logic commit_in;
  logic [N-1:0] commit_mask_in;
  logic rd_en_in;
  logic [WC-1:0] rd_chan_in;
  logic [3:0] rd_addr_in;
  logic [WD-1:0] rd_data_out;
  logic rd_valid_out;
  logic snap_in;
  logic [N-1:0] adc_valid_in;
  logic [N*WA-1:0] adc_data_in;
  logic [N*WA-1:0] adc_snap_out;
  logic [N-1:0] adc_fresh_out;
  logic [N*WD-1:0] setpoint_out, p_coef_out, i_coef_out, d_coef_out;
  logic [N*WD-1:0] osf_cycle_delay_out, osf_log_ovr_out, src_sel_out;
  logic [N-1:0] lock_en_out, update_en_out, dirty_out;
  logic wr_err_out;

  chan_param_bank #(.N_CHAN(N), .W_DATA(WD), .W_ADC(WA), .W_CH(WC)) dut (
    .clk50_in(clk50_in), .reset_in(reset_in),
    .wr_en_in(wr_en_in), .wr_chan_in(wr_chan_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .commit_in(commit_in), .commit_mask_in(commit_mask_in),
    .rd_en_in(rd_en_in), .rd_chan_in(rd_chan_in), .rd_addr_in(rd_addr_in),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out),
    .snap_in(snap_in), .adc_valid_in(adc_valid_in), .adc_data_in(adc_data_in),
    .adc_snap_out(adc_snap_out), .adc_fresh_out(adc_fresh_out),
    .setpoint_out(setpoint_out), .p_coef_out(p_coef_out), .i_coef_out(i_coef_out),
    .d_coef_out(d_coef_out), .osf_cycle_delay_out(osf_cycle_delay_out),
    .osf_log_ovr_out(osf_log_ovr_out), .src_sel_out(src_sel_out),
    .lock_en_out(lock_en_out), .update_en_out(update_en_out), .dirty_out(dirty_out),
    .wr_err_out(wr_err_out)
  );

  always #10 clk50_in = ~clk50_in;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [WD-1:0] m_sh [N][8];
  logic [WD-1:0] m_ac [N][8];
  logic [WA-1:0] m_latch [N];
  logic [WA-1:0] m_snap [N];
  logic [N-1:0] m_dirty, m_upd, m_fresh;
  logic m_wr_err, m_rd_valid;
  logic [WD-1:0] m_rd_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge to the model, in the order the rules imply.
  task automatic model_step();
    if (reset_in) begin
      for (int c = 0; c < N; c++) begin
        for (int r = 0; r < 8; r++) begin
          m_sh[c][r] = '0;
          m_ac[c][r] = '0;
        end
        m_latch[c] = '0;
        m_snap[c] = '0;
      end
      m_dirty = '0; m_upd = '0; m_fresh = '0;
      m_wr_err = 0; m_rd_valid = 0; m_rd_data = '0;
      return;
    end
    m_rd_valid = rd_en_in;
    if (rd_en_in) begin
      if (int'(rd_chan_in) >= N) m_rd_data = '0;
      else if (rd_addr_in < 8) m_rd_data = m_sh[rd_chan_in][rd_addr_in[2:0]];
      else m_rd_data = m_ac[rd_chan_in][rd_addr_in - 4'd8];
    end
    m_upd = '0;
    if (commit_in) begin
      for (int c = 0; c < N; c++) begin
        if (commit_mask_in[c]) begin
          for (int r = 0; r < 8; r++) m_ac[c][r] = m_sh[c][r];
          m_upd[c] = 1;
          m_dirty[c] = 0;
        end
      end
    end
    m_wr_err = 0;
    if (wr_en_in) begin
      if (int'(wr_chan_in) < N) begin
        m_sh[wr_chan_in][wr_addr_in] = wr_data_in;
        m_dirty[wr_chan_in] = 1;
      end else begin
        m_wr_err = 1;
      end
    end
    if (snap_in) begin
      for (int c = 0; c < N; c++) m_snap[c] = m_latch[c];
      m_fresh = '0;
    end
    for (int c = 0; c < N; c++) begin
      if (adc_valid_in[c]) begin
        m_latch[c] = adc_data_in[c*WA +: WA];
        m_fresh[c] = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [N*WD-1:0] e [7];
    logic [N*WA-1:0] es;
    logic [N-1:0] el;
    for (int c = 0; c < N; c++) begin
      e[0][c*WD +: WD] = m_ac[c][0];
      e[1][c*WD +: WD] = m_ac[c][1];
      e[2][c*WD +: WD] = m_ac[c][2];
      e[3][c*WD +: WD] = m_ac[c][3];
      e[4][c*WD +: WD] = m_ac[c][4];
      e[5][c*WD +: WD] = m_ac[c][5];
      e[6][c*WD +: WD] = m_ac[c][7];
      el[c] = m_ac[c][6][0];
      es[c*WA +: WA] = m_snap[c];
    end
    check("setpoint", setpoint_out, e[0]);
    check("p_coef", p_coef_out, e[1]);
    check("i_coef", i_coef_out, e[2]);
    check("d_coef", d_coef_out, e[3]);
    check("osf_cycle_delay", osf_cycle_delay_out, e[4]);
    check("osf_log_ovr", osf_log_ovr_out, e[5]);
    check("src_sel", src_sel_out, e[6]);
    check("lock_en", lock_en_out, el);
    check("adc_snap", adc_snap_out, es);
    check("adc_fresh", adc_fresh_out, m_fresh);
    check("update_en", update_en_out, m_upd);
    check("dirty", dirty_out, m_dirty);
    check("wr_err", wr_err_out, m_wr_err);
    check("rd_valid", rd_valid_out, m_rd_valid);
    check("rd_data", rd_data_out, m_rd_data);
  endtask

  // Single compare process: advance model on each edge, check DUT just after it.
  initial begin
    forever begin
      @(posedge clk50_in);
      model_step();
      #1;
      compare_all();
    end
  end

  task automatic idle();
    wr_en_in = 0; wr_chan_in = '0; wr_addr_in = '0; wr_data_in = '0;
    commit_in = 0; commit_mask_in = '0; rd_en_in = 0; rd_chan_in = '0; rd_addr_in = '0;
    snap_in = 0; adc_valid_in = '0; adc_data_in = '0;
  endtask

  task automatic cyc();
    @(posedge clk50_in);
    @(negedge clk50_in);
  endtask

  task automatic wr(input int ch, input int addr, input logic [WD-1:0] d);
    wr_en_in = 1; wr_chan_in = WC'(ch); wr_addr_in = 3'(addr); wr_data_in = d;
  endtask

  task automatic rd(input int ch, input int addr);
    rd_en_in = 1; rd_chan_in = WC'(ch); rd_addr_in = 4'(addr);
  endtask

  initial begin
    idle();
    reset_in = 1;
    repeat (3) cyc();
    reset_in = 0;

    // Idle after reset: nothing moves for 20 cycles.
    repeat (20) begin
      cyc();
      check("idle_update_en", update_en_out, '0);
    end
    check("idle_dirty", dirty_out, '0);
    check("idle_rd_valid", rd_valid_out, 1'b0);

    // Write ch2 p_coef, read shadow/active, commit, read again.
    wr(2, 1, 16'h1234); cyc(); idle();
    check("dirty2_set", dirty_out[2], 1'b1);
    rd(2, 1); cyc();
    check("rd_sh_pre_valid", rd_valid_out, 1'b1);
    check("rd_sh_pre", rd_data_out, 16'h1234);
    rd(2, 9); cyc(); idle();
    check("rd_ac_pre", rd_data_out, 16'h0000);
    commit_in = 1; commit_mask_in = 8'h04; cyc(); idle();
    check("p_coef2", p_coef_out[2*WD +: WD], 16'h1234);
    check("upd_pulse", update_en_out, 8'h04);
    check("dirty2_clr", dirty_out[2], 1'b0);
    check("p_coef_others", p_coef_out & ~({{(N*WD-WD){1'b0}}, 16'hFFFF} << (2*WD)), '0);
    cyc();
    check("upd_one_cycle", update_en_out, 8'h00);
    check("rd_valid_hold", rd_valid_out, 1'b0);
    check("rd_data_hold", rd_data_out, 16'h0000);
    rd(2, 1); cyc();
    check("rd_sh_post", rd_data_out, 16'h1234);
    rd(2, 9); cyc(); idle();
    check("rd_ac_post", rd_data_out, 16'h1234);

    // Write and commit on the same channel in the same cycle.
    wr(3, 0, 16'hAAAA); cyc();
    wr(3, 0, 16'h5555); commit_in = 1; commit_mask_in = 8'h08; cyc(); idle();
    check("wc_setpoint3", setpoint_out[3*WD +: WD], 16'hAAAA);
    check("wc_dirty3", dirty_out[3], 1'b1);
    commit_in = 1; commit_mask_in = 8'h08; cyc(); idle();
    check("wc_setpoint3_2", setpoint_out[3*WD +: WD], 16'h5555);
    check("wc_dirty3_2", dirty_out[3], 1'b0);

    // Zero-mask commit does nothing.
    commit_in = 1; commit_mask_in = 8'h00; cyc(); idle();
    check("zero_mask_upd", update_en_out, 8'h00);

    // Out-of-range write, then sweep all readbacks (model checks every value).
    wr(N, 0, 16'hDEAD); cyc(); idle();
    check("wr_err_pulse", wr_err_out, 1'b1);
    cyc();
    check("wr_err_single", wr_err_out, 1'b0);
    for (int ch = 0; ch < 16; ch++) begin
      for (int a = 0; a < 16; a++) begin
        rd(ch, a); cyc();
      end
    end
    idle();
    rd(N, 0); cyc(); idle();
    check("rd_oob_valid", rd_valid_out, 1'b1);
    check("rd_oob_zero", rd_data_out, 16'h0000);

    // ADC sample and snapshot in the same cycle.
    adc_valid_in = 8'h01; adc_data_in[0 +: WA] = 18'h2ABCD; snap_in = 1; cyc(); idle();
    check("snap_old", adc_snap_out[0 +: WA], 18'h0);
    check("fresh_kept", adc_fresh_out[0], 1'b1);
    snap_in = 1; cyc(); idle();
    check("snap_new", adc_snap_out[0 +: WA], 18'h2ABCD);
    check("fresh_clr", adc_fresh_out[0], 1'b0);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 4000; i++) begin
      reset_in = ($urandom_range(0, 299) == 0);
      wr_en_in = $urandom_range(0, 1);
      wr_chan_in = ($urandom_range(0, 7) == 0) ? WC'($urandom_range(0, 15))
                                               : WC'($urandom_range(0, N - 1));
      wr_addr_in = 3'($urandom_range(0, 7));
      wr_data_in = WD'($urandom);
      commit_in = ($urandom_range(0, 3) == 0);
      commit_mask_in = N'($urandom);
      rd_en_in = $urandom_range(0, 1);
      rd_chan_in = WC'($urandom_range(0, 15));
      rd_addr_in = 4'($urandom_range(0, 15));
      snap_in = ($urandom_range(0, 7) == 0);
      adc_valid_in = N'($urandom);
      for (int c = 0; c < N; c++) adc_data_in[c*WA +: WA] = WA'($urandom);
      cyc();
    end
    reset_in = 0;
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
